// File: rtl/op_cycle_sequencer_pkg.sv
// op_cycle_sequencer_pkg
// Shared definitions for the multicycle-operation sequencer:
//   - state_t        : sequencer state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - DEFAULT_CNT_W  : default counter / terminal-count width
package op_cycle_sequencer_pkg;

  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : op_cycle_sequencer_pkg

// File: rtl/op_cycle_sequencer_sync_counter.sv
// sync_counter
// CNT_W-bit cycle counter with synchronous clear and increment enable, plus
// a look-ahead compare telling the sequencer that the next increment would
// land on the terminal value.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset (clears the count)
//   clear   in   synchronous clear, has priority over inc
//   inc     in   increment enable
//   term    in   CNT_W  terminal value to compare against
//   count   out  CNT_W  current count
//   at_term out  high when count+1 equals term
module sync_counter
  import op_cycle_sequencer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_next;

  assign count_next = count + ONE;

  // The sum wraps only when count is all ones, which happens solely while
  // holding a full-scale terminal value in DONE; the compare is ignored there
  // and term is never zero, so the wrap cannot cause a false hit.
  assign at_term = (count_next == term);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count_next;
    end
  end

endmodule : sync_counter

// File: rtl/op_cycle_sequencer.sv
// op_cycle_sequencer
// Multicycle-operation sequencer for iterative units (multiplier/divider
// control path). Accepts a start with a runtime terminal count, counts RUN
// cycles with stall and abort support, in one-shot or continuous mode.
// Ports:
//   clk    in   system clock, all state updates on rising edge
//   reset  in   synchronous active-high reset, beats every other input
//   start  in   request a new operation (taken in IDLE or DONE only)
//   term   in   CNT_W terminal count, 0 selects DEFAULT_TERM
//   cont   in   0 one-shot, 1 continuous auto-reload
//   stall  in   hold the count while in RUN
//   abort  in   cancel the operation, back to IDLE
//   busy   out  high while in RUN
//   done   out  one-cycle pulse per terminal event
//   ready  out  sticky completion flag
//   count  out  CNT_W current cycle count
module op_cycle_sequencer
  import op_cycle_sequencer_pkg::*;
#(
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int DEFAULT_TERM = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] term,
  input  logic             cont,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEF_TERM = CNT_W'(DEFAULT_TERM);

  state_t           state;
  logic [CNT_W-1:0] term_q;
  logic             cont_q;

  logic start_ok;
  logic abort_act;
  logic run_step;
  logic at_term;
  logic term_hit;
  logic reload;
  logic cnt_clear;
  logic cnt_inc;

  // Abort outranks start, stall and the terminal event in the same cycle.
  assign start_ok  = start && !abort && (state == ST_IDLE || state == ST_DONE);
  assign abort_act = abort && (state == ST_RUN || state == ST_DONE);
  assign run_step  = (state == ST_RUN) && !stall && !abort;
  assign term_hit  = run_step && at_term;
  assign reload    = term_hit && cont_q;

  // One-shot terminal simply increments onto term_q; continuous reloads to 0.
  assign cnt_clear = abort_act || start_ok || reload;
  assign cnt_inc   = run_step && !reload;

  sync_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .inc     (cnt_inc),
    .term    (term_q),
    .count   (count),
    .at_term (at_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      term_q <= '0;
      cont_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_act) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        ready <= 1'b0;
      end else if (start_ok) begin
        term_q <= (term == '0) ? DEF_TERM : term;
        cont_q <= cont;
        state  <= ST_RUN;
        busy   <= 1'b1;
        ready  <= 1'b0;
      end else if (term_hit) begin
        done  <= 1'b1;
        ready <= 1'b1;
        if (!cont_q) begin
          state <= ST_DONE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule : op_cycle_sequencer

// File: tb/tb_op_cycle_sequencer.sv
// tb_op_cycle_sequencer
// Directed self-checking bench for op_cycle_sequencer (CNT_W=6,
// DEFAULT_TERM=16). Inputs change 1ns after a rising edge and outputs are
// checked at the same point, i.e. they show the result of that edge.
module tb_op_cycle_sequencer;

  localparam int CNT_W = 6;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] term;
  logic             cont;
  logic             stall;
  logic             abort;
  logic             busy;
  logic             done;
  logic             ready;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;

  op_cycle_sequencer #(
    .CNT_W        (CNT_W),
    .DEFAULT_TERM (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .term  (term),
    .cont  (cont),
    .stall (stall),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .ready (ready),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then advance to 1ns after the next rising edge.
  task automatic applyStimulus(input logic s, input logic [CNT_W-1:0] t,
                               input logic c, input logic st, input logic ab);
    start = s;
    term  = t;
    cont  = c;
    stall = st;
    abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic b, input logic d,
                             input logic r, input logic [CNT_W-1:0] c);
    checks++;
    assert (busy === b) else begin
      failures++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, b);
    end
    checks++;
    assert (done === d) else begin
      failures++;
      $error("[TB] FAIL %s done observed=%b expected=%b", tag, done, d);
    end
    checks++;
    assert (ready === r) else begin
      failures++;
      $error("[TB] FAIL %s ready observed=%b expected=%b", tag, ready, r);
    end
    checks++;
    assert (count === c) else begin
      failures++;
      $error("[TB] FAIL %s count observed=%0d expected=%0d", tag, count, c);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    term  = '0;
    cont  = 1'b0;
    stall = 1'b0;
    abort = 1'b0;

    // Reset state
    idleStep();
    idleStep();
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 6'd0);
    reset = 1'b0;
    idleStep();
    checkOutput("idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // Default term (0 -> 16), one-shot: count 0..15 while busy, then done
    applyStimulus(1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("def_start", 1'b1, 1'b0, 1'b0, 6'd0);
    for (int i = 1; i <= 15; i++) begin
      idleStep();
      checkOutput("def_run", 1'b1, 1'b0, 1'b0, 6'(i));
    end
    idleStep();
    checkOutput("def_done", 1'b0, 1'b1, 1'b1, 6'd16);
    idleStep();
    checkOutput("def_hold", 1'b0, 1'b0, 1'b1, 6'd16);
    idleStep();
    checkOutput("def_hold2", 1'b0, 1'b0, 1'b1, 6'd16);

    // term=5 with a 3-cycle stall; start taken from DONE clears ready
    applyStimulus(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("st_start", 1'b1, 1'b0, 1'b0, 6'd0);
    idleStep();
    checkOutput("st_c1", 1'b1, 1'b0, 1'b0, 6'd1);
    idleStep();
    checkOutput("st_c2", 1'b1, 1'b0, 1'b0, 6'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("st_stall", 1'b1, 1'b0, 1'b0, 6'd2);
    end
    idleStep();
    checkOutput("st_c3", 1'b1, 1'b0, 1'b0, 6'd3);
    idleStep();
    checkOutput("st_c4", 1'b1, 1'b0, 1'b0, 6'd4);
    idleStep();
    checkOutput("st_done", 1'b0, 1'b1, 1'b1, 6'd5);

    // Continuous term=4: done every 4 cycles, count 0,1,2,3,0,...
    applyStimulus(1'b1, 6'd4, 1'b1, 1'b0, 1'b0);
    checkOutput("ct_start", 1'b1, 1'b0, 1'b0, 6'd0);
    for (int i = 1; i <= 3; i++) begin
      idleStep();
      checkOutput("ct_run1", 1'b1, 1'b0, 1'b0, 6'(i));
    end
    idleStep();
    checkOutput("ct_done1", 1'b1, 1'b1, 1'b1, 6'd0);
    for (int i = 1; i <= 3; i++) begin
      idleStep();
      checkOutput("ct_run2", 1'b1, 1'b0, 1'b1, 6'(i));
    end
    idleStep();
    checkOutput("ct_done2", 1'b1, 1'b1, 1'b1, 6'd0);
    idleStep();
    checkOutput("ct_c1", 1'b1, 1'b0, 1'b1, 6'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ct_abort", 1'b0, 1'b0, 1'b0, 6'd0);

    // Mid-run start ignored (term=9 not latched), then abort+start in DONE
    applyStimulus(1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("mr_start", 1'b1, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b1, 6'd9, 1'b1, 1'b0, 1'b0);
    checkOutput("mr_ignored", 1'b1, 1'b0, 1'b0, 6'd1);
    idleStep();
    checkOutput("mr_c2", 1'b1, 1'b0, 1'b0, 6'd2);
    idleStep();
    checkOutput("mr_done", 1'b0, 1'b1, 1'b1, 6'd3);
    applyStimulus(1'b1, 6'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("ab_wins", 1'b0, 1'b0, 1'b0, 6'd0);
    idleStep();
    checkOutput("ab_idle", 1'b0, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ab_in_idle", 1'b0, 1'b0, 1'b0, 6'd0);

    // Reset mid-run at count 7, then normal restart with term=2
    applyStimulus(1'b1, 6'd20, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) idleStep();
    checkOutput("rs_c7", 1'b1, 1'b0, 1'b0, 6'd7);
    reset = 1'b1;
    idleStep();
    reset = 1'b0;
    checkOutput("rs_mid", 1'b0, 1'b0, 1'b0, 6'd0);
    idleStep();
    checkOutput("rs_idle", 1'b0, 1'b0, 1'b0, 6'd0);
    applyStimulus(1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("rs_start", 1'b1, 1'b0, 1'b0, 6'd0);
    idleStep();
    checkOutput("rs_c1", 1'b1, 1'b0, 1'b0, 6'd1);
    idleStep();
    checkOutput("rs_done", 1'b0, 1'b1, 1'b1, 6'd2);

    // term=1: done on the first RUN edge; start with stall from DONE is taken
    applyStimulus(1'b1, 6'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_start", 1'b1, 1'b0, 1'b0, 6'd0);
    idleStep();
    checkOutput("t1_done", 1'b0, 1'b1, 1'b1, 6'd1);

    // term=63: full-scale count without wrap
    applyStimulus(1'b1, 6'd63, 1'b0, 1'b0, 1'b0);
    checkOutput("t63_start", 1'b1, 1'b0, 1'b0, 6'd0);
    for (int i = 1; i <= 62; i++) idleStep();
    checkOutput("t63_c62", 1'b1, 1'b0, 1'b0, 6'd62);
    idleStep();
    checkOutput("t63_done", 1'b0, 1'b1, 1'b1, 6'd63);
    idleStep();
    checkOutput("t63_hold", 1'b0, 1'b0, 1'b1, 6'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_op_cycle_sequencer
